// File: rtl/uart_tx_sched_if.sv
// Register-side, transmitter-side and status signals of the UART transmit scheduler.
interface uart_tx_sched_if;
  logic       thr_wr;
  logic [7:0] thr_wdata;
  logic       fifo_en;
  logic       txfifo_clr;
  logic       iir_rd;
  logic       tsr_load;
  logic       shift_cnt_eq;
  logic       transmit_edge;
  logic       thre;
  logic [7:0] tx_data;
  logic       temt;
  logic [4:0] tx_level;
  logic       thre_int;
  logic       wr_drop;

  modport master (
    output thr_wr, thr_wdata, fifo_en, txfifo_clr, iir_rd,
    output tsr_load, shift_cnt_eq, transmit_edge,
    input  thre, tx_data, temt, tx_level, thre_int, wr_drop
  );

  modport slave (
    input  thr_wr, thr_wdata, fifo_en, txfifo_clr, iir_rd,
    input  tsr_load, shift_cnt_eq, transmit_edge,
    output thre, tx_data, temt, tx_level, thre_int, wr_drop
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit holding/FIFO scheduler with THR-empty interrupt and TSR tracking.
// Define UART_TX_FIFO_EN for the 16-entry FIFO; otherwise a single holding register is built.
module uart_tx_sched (
  input  logic            pclk,
  input  logic            preset,
  uart_tx_sched_if.slave  bus
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = 4;
  localparam int unsigned CW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_wr_drop;
  logic          r_thre_int;
  logic          r_thre_q;

  logic          w_fifo_mode;
  logic          w_clear;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovwr;
  logic          w_drop;
  logic          w_eos;
  logic [DW-1:0] w_head;
  logic [CW-1:0] w_count_nxt;

`ifdef UART_TX_FIFO_EN
  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_fifo_en_q;

  // A mode change flushes the queue just like an explicit clear.
  assign w_fifo_mode = bus.fifo_en;
  assign w_clear     = bus.txfifo_clr | (bus.fifo_en != r_fifo_en_q);
  assign w_full      = w_fifo_mode ? (r_count == CW'(DEPTH)) : (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.thr_wdata;
    end else if (w_ovwr) begin
      r_mem[r_rd_ptr] <= bus.thr_wdata;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_fifo_en_q <= 1'b0;
    end else begin
      r_fifo_en_q <= bus.fifo_en;
      if (w_clear) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      end
    end
  end

  assign bus.tx_level = r_count;
`else
  logic [DW-1:0] r_hold;
  logic          w_unused_fifo_en;

  // Holding-register build: fifo_en has no effect, depth is always one.
  assign w_unused_fifo_en = bus.fifo_en;
  assign w_fifo_mode      = 1'b0;
  assign w_clear          = bus.txfifo_clr;
  assign w_full           = (r_count != '0);
  assign w_head           = r_hold;

  always_ff @(posedge pclk) begin
    if (w_push | w_ovwr) begin
      r_hold <= bus.thr_wdata;
    end
  end

  assign bus.tx_level = CW'(r_count[0]);
`endif

  // Write/pop arbitration; a full queue accepts a write only when the head leaves in the same cycle.
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.tsr_load & ~w_empty;
  assign w_push  = bus.thr_wr & ~w_clear & (~w_full | w_pop);
  assign w_ovwr  = bus.thr_wr & ~w_clear & w_full & ~w_pop & ~w_fifo_mode;
  assign w_drop  = bus.thr_wr & ~w_clear & w_full & ~w_pop & w_fifo_mode;
  assign w_eos   = bus.shift_cnt_eq & bus.transmit_edge;

  always_comb begin
    w_count_nxt = r_count;
    if (w_clear) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Occupancy, drop pulse, THR-empty interrupt and transmitter state.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_wr_drop  <= 1'b0;
      r_thre_int <= 1'b0;
      r_thre_q   <= 1'b1;
    end else begin
      r_count   <= w_count_nxt;
      r_wr_drop <= w_drop;
      r_thre_q  <= w_empty;
      if (w_empty & ~r_thre_q) begin
        r_thre_int <= 1'b1;
      end else if (bus.iir_rd | w_push | w_ovwr) begin
        r_thre_int <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_SHIFT;
          end else if (~w_empty & ~w_clear) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_pop) begin
            r_state <= ST_SHIFT;
          end else if (w_clear | w_empty) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_eos & ~w_pop) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.thre     = w_empty;
  assign bus.tx_data  = w_empty ? '0 : w_head;
  assign bus.temt     = (r_state == ST_IDLE) & w_empty;
  assign bus.thre_int = r_thre_int;
  assign bus.wr_drop  = r_wr_drop;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a byte queue holds the expected FIFO contents and is
// checked against tx_data on every transmitter load; scenario tasks check flags inline.
module tb_uart_tx_sched;

  logic pclk;
  logic preset;

  uart_tx_sched_if bus ();

  uart_tx_sched dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
`ifdef UART_TX_FIFO_EN
  logic m_fen_d = 1'b0;
  localparam bit FIFO_BUILD = 1'b1;
`else
  localparam bit FIFO_BUILD = 1'b0;
`endif

  function automatic logic fifo_mode();
`ifdef UART_TX_FIFO_EN
    return bus.fifo_en;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    bus.thr_wr        = 1'b0;
    bus.thr_wdata     = 8'h00;
    bus.txfifo_clr    = 1'b0;
    bus.iir_rd        = 1'b0;
    bus.tsr_load      = 1'b0;
    bus.shift_cnt_eq  = 1'b0;
    bus.transmit_edge = 1'b0;
  endtask

  // One clock: drive at the falling edge, score any load, return at the next falling edge.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic ld,
                     input logic clr, input logic iir, input logic eos);
    logic [7:0] exp_b;
    logic       clear;
    int         depth;
    bus.thr_wr        = wr;
    bus.thr_wdata     = d;
    bus.tsr_load      = ld;
    bus.txfifo_clr    = clr;
    bus.iir_rd        = iir;
    bus.shift_cnt_eq  = eos;
    bus.transmit_edge = eos;
    depth = fifo_mode() ? 16 : 1;
    clear = clr;
`ifdef UART_TX_FIFO_EN
    if (bus.fifo_en !== m_fen_d) clear = 1'b1;
    m_fen_d = bus.fifo_en;
`endif
    if (ld && exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (bus.tx_data !== exp_b) begin
        errors++;
        $display("FAIL sb_tx_data: got 0x%02h expected 0x%02h", bus.tx_data, exp_b);
      end
    end
    if (clear) begin
      exp_q.delete();
    end else if (wr) begin
      if (exp_q.size() < depth) exp_q.push_back(d);
      else if (depth == 1)      exp_q[0] = d;
    end
    @(posedge pclk);
    @(negedge pclk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.fifo_en = 1'b0;
    preset      = 1'b1;
    bus.thr_wr  = 1'b1;
    bus.thr_wdata = 8'h5A;
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (bus.thre !== 1'b1)      begin errors++; $display("FAIL rst_thre: got %b expected 1", bus.thre); end
    checks++; if (bus.temt !== 1'b1)      begin errors++; $display("FAIL rst_temt: got %b expected 1", bus.temt); end
    checks++; if (bus.tx_data !== 8'h00)  begin errors++; $display("FAIL rst_tx_data: got 0x%02h expected 0x00", bus.tx_data); end
    checks++; if (bus.tx_level !== 5'd0)  begin errors++; $display("FAIL rst_tx_level: got %0d expected 0", bus.tx_level); end
    checks++; if (bus.thre_int !== 1'b0)  begin errors++; $display("FAIL rst_thre_int: got %b expected 0", bus.thre_int); end
    checks++; if (bus.wr_drop !== 1'b0)   begin errors++; $display("FAIL rst_wr_drop: got %b expected 0", bus.wr_drop); end
    idle_inputs();
    preset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_nonfifo_basic();
    bus.fifo_en = 1'b0;
    cyc(1, 8'hA5, 0, 0, 0, 0);
    checks++; if (bus.thre !== 1'b0)     begin errors++; $display("FAIL nf_thre_low: got %b expected 0", bus.thre); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL nf_tx_data: got 0x%02h expected 0xa5", bus.tx_data); end
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    checks++; if (bus.thre !== 1'b1)     begin errors++; $display("FAIL nf_thre_high: got %b expected 1", bus.thre); end
    checks++; if (bus.temt !== 1'b0)     begin errors++; $display("FAIL nf_temt_shift: got %b expected 0", bus.temt); end
    checks++; if (bus.thre_int !== 1'b0) begin errors++; $display("FAIL nf_int_early: got %b expected 0", bus.thre_int); end
    cyc(0, 8'h00, 0, 0, 0, 0);
    checks++; if (bus.thre_int !== 1'b1) begin errors++; $display("FAIL nf_int_set: got %b expected 1", bus.thre_int); end
    cyc(0, 8'h00, 0, 0, 0, 1);
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL nf_temt_end: got %b expected 1", bus.temt); end
    cyc(0, 8'h00, 0, 0, 1, 0);
    checks++; if (bus.thre_int !== 1'b0) begin errors++; $display("FAIL nf_int_iir: got %b expected 0", bus.thre_int); end
    // Overwrite while the holding register is occupied
    cyc(1, 8'h11, 0, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0, 0);
    checks++; if (bus.tx_level !== 5'd1) begin errors++; $display("FAIL nf_ovwr_level: got %0d expected 1", bus.tx_level); end
    checks++; if (bus.wr_drop !== 1'b0)  begin errors++; $display("FAIL nf_ovwr_drop: got %b expected 0", bus.wr_drop); end
    checks++; if (bus.tx_data !== 8'h22) begin errors++; $display("FAIL nf_ovwr_data: got 0x%02h expected 0x22", bus.tx_data); end
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(1, 8'h33, 1, 0, 0, 0);
    checks++; if (bus.tx_data !== 8'h33) begin errors++; $display("FAIL nf_wrld_data: got 0x%02h expected 0x33", bus.tx_data); end
    checks++; if (bus.tx_level !== 5'd1) begin errors++; $display("FAIL nf_wrld_level: got %0d expected 1", bus.tx_level); end
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL nf_temt_final: got %b expected 1", bus.temt); end
  endtask

  task automatic test_fifo_fill();
    int drops;
    logic [4:0] exp_level;
    logic [7:0] exp_head;
    int exp_drops;
    exp_level = FIFO_BUILD ? 5'd16 : 5'd1;
    exp_head  = FIFO_BUILD ? 8'h00 : 8'h10;
    exp_drops = FIFO_BUILD ? 1 : 0;
    bus.fifo_en = 1'b1;
    cyc(0, 8'h00, 0, 0, 0, 0);
    drops = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(1, 8'(i), 0, 0, 0, 0);
      if (bus.wr_drop === 1'b1) drops++;
    end
    cyc(0, 8'h00, 0, 0, 0, 0);
    if (bus.wr_drop === 1'b1) drops++;
    checks++; if (bus.tx_level !== exp_level) begin errors++; $display("FAIL fill_level: got %0d expected %0d", bus.tx_level, exp_level); end
    checks++; if (drops != exp_drops)         begin errors++; $display("FAIL fill_drops: got %0d expected %0d", drops, exp_drops); end
    checks++; if (bus.tx_data !== exp_head)   begin errors++; $display("FAIL fill_head: got 0x%02h expected 0x%02h", bus.tx_data, exp_head); end
  endtask

  task automatic test_full_pop();
    logic [4:0] exp_level;
    logic [7:0] exp_head;
    exp_level = FIFO_BUILD ? 5'd16 : 5'd1;
    exp_head  = FIFO_BUILD ? 8'h01 : 8'h55;
    cyc(1, 8'h55, 1, 0, 0, 0);
    checks++; if (bus.tx_level !== exp_level) begin errors++; $display("FAIL fullpop_level: got %0d expected %0d", bus.tx_level, exp_level); end
    checks++; if (bus.tx_data !== exp_head)   begin errors++; $display("FAIL fullpop_head: got 0x%02h expected 0x%02h", bus.tx_data, exp_head); end
    checks++; if (bus.wr_drop !== 1'b0)       begin errors++; $display("FAIL fullpop_drop: got %b expected 0", bus.wr_drop); end
  endtask

  task automatic test_drain_int();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      cyc(0, 8'h00, 1, 0, 0, 1);
      n++;
    end
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL drain_bound: got %0d left expected 0", exp_q.size()); end
    checks++; if (bus.thre !== 1'b1)     begin errors++; $display("FAIL drain_thre: got %b expected 1", bus.thre); end
    checks++; if (bus.thre_int !== 1'b0) begin errors++; $display("FAIL drain_int_early: got %b expected 0", bus.thre_int); end
    cyc(0, 8'h00, 0, 0, 0, 1);
    checks++; if (bus.thre_int !== 1'b1) begin errors++; $display("FAIL drain_int_set: got %b expected 1", bus.thre_int); end
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL drain_temt: got %b expected 1", bus.temt); end
    cyc(0, 8'h00, 0, 0, 1, 0);
    checks++; if (bus.thre_int !== 1'b0) begin errors++; $display("FAIL drain_int_iir: got %b expected 0", bus.thre_int); end
    cyc(1, 8'h9A, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    checks++; if (bus.thre_int !== 1'b1) begin errors++; $display("FAIL drain_set_wins: got %b expected 1", bus.thre_int); end
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(1, 8'h5B, 0, 0, 0, 0);
    checks++; if (bus.thre_int !== 1'b0) begin errors++; $display("FAIL drain_int_wr: got %b expected 0", bus.thre_int); end
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
  endtask

  task automatic test_clear_in_shift();
    cyc(1, 8'hC1, 0, 0, 0, 0);
    cyc(1, 8'hC2, 0, 0, 0, 0);
    cyc(1, 8'hC3, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(1, 8'h77, 0, 1, 0, 0);
    checks++; if (bus.tx_level !== 5'd0) begin errors++; $display("FAIL clr_level: got %0d expected 0", bus.tx_level); end
    checks++; if (bus.thre !== 1'b1)     begin errors++; $display("FAIL clr_thre: got %b expected 1", bus.thre); end
    checks++; if (bus.temt !== 1'b0)     begin errors++; $display("FAIL clr_temt_busy: got %b expected 0", bus.temt); end
    checks++; if (bus.wr_drop !== 1'b0)  begin errors++; $display("FAIL clr_wr_drop: got %b expected 0", bus.wr_drop); end
    cyc(0, 8'h00, 0, 0, 0, 0);
    checks++; if (bus.temt !== 1'b0)     begin errors++; $display("FAIL clr_temt_hold: got %b expected 0", bus.temt); end
    cyc(0, 8'h00, 0, 0, 0, 1);
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL clr_temt_end: got %b expected 1", bus.temt); end
  endtask

  task automatic test_mode_change();
    logic [4:0] exp_level;
    exp_level = FIFO_BUILD ? 5'd0 : 5'd1;
    cyc(1, 8'hD1, 0, 0, 0, 0);
    cyc(1, 8'hD2, 0, 0, 0, 0);
    bus.fifo_en = 1'b0;
    cyc(1, 8'hD3, 0, 0, 0, 0);
    checks++; if (bus.tx_level !== exp_level) begin errors++; $display("FAIL mode_level: got %0d expected %0d", bus.tx_level, exp_level); end
    checks++; if (bus.wr_drop !== 1'b0)       begin errors++; $display("FAIL mode_drop: got %b expected 0", bus.wr_drop); end
    cyc(0, 8'h00, 0, 1, 0, 0);
    checks++; if (bus.temt !== 1'b1)          begin errors++; $display("FAIL mode_temt: got %b expected 1", bus.temt); end
  endtask

  task automatic test_reset_mid_shift();
    logic [4:0] exp_level;
    exp_level = FIFO_BUILD ? 5'd5 : 5'd0;
    bus.fifo_en = 1'b1;
    cyc(0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 8'hE0 + 8'(i), 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    checks++; if (bus.tx_level !== exp_level) begin errors++; $display("FAIL rms_level: got %0d expected %0d", bus.tx_level, exp_level); end
    #2 preset = 1'b1;
    #1;
    checks++; if (bus.thre !== 1'b1)     begin errors++; $display("FAIL rms_thre: got %b expected 1", bus.thre); end
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL rms_temt: got %b expected 1", bus.temt); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rms_tx_data: got 0x%02h expected 0x00", bus.tx_data); end
    checks++; if (bus.tx_level !== 5'd0) begin errors++; $display("FAIL rms_tx_level: got %0d expected 0", bus.tx_level); end
    checks++; if (bus.thre_int !== 1'b0) begin errors++; $display("FAIL rms_thre_int: got %b expected 0", bus.thre_int); end
    checks++; if (bus.wr_drop !== 1'b0)  begin errors++; $display("FAIL rms_wr_drop: got %b expected 0", bus.wr_drop); end
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL rms_hold_temt: got %b expected 1", bus.temt); end
    preset = 1'b0;
    exp_q.delete();
`ifdef UART_TX_FIFO_EN
    m_fen_d = 1'b0;
`endif
    cyc(0, 8'h00, 0, 0, 0, 0);
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL rms_post_temt: got %b expected 1", bus.temt); end
    cyc(1, 8'h3C, 0, 0, 0, 0);
    checks++; if (bus.tx_data !== 8'h3C) begin errors++; $display("FAIL rms_post_data: got 0x%02h expected 0x3c", bus.tx_data); end
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    checks++; if (bus.temt !== 1'b1)     begin errors++; $display("FAIL rms_post_end: got %b expected 1", bus.temt); end
  endtask

  initial begin
    test_reset();
    test_nonfifo_basic();
    test_fifo_fill();
    test_full_pop();
    test_drain_int();
    test_clear_in_shift();
    test_mode_change();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
